// File: rtl/sync_up_counter.sv
// Fully synchronous modulo-MODULUS up counter with parallel load, terminal count
// for cascading, a wrap pulse, a sticky overflow flag and an illegal-load pulse.
module sync_up_counter #(
    parameter int WIDTH   = 3,
    parameter int MODULUS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             ovf,
    output logic             load_err
);
    localparam bit               IS_POW2 = (MODULUS & (MODULUS - 1)) == 0;
    localparam logic [WIDTH-1:0] TOP     = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic             at_top;
    logic             do_count;
    logic             do_wrap;
    logic             load_ok;
    logic [WIDTH-1:0] q_inc;

    assign at_top   = (q == TOP);
    assign do_count = en & ~load;
    assign do_wrap  = do_count & at_top;
    assign tc       = do_wrap;
    assign load_ok  = ({1'b0, load_val} < MOD_EXT);

    generate
        if (IS_POW2) begin : g_toggle
            // Bit i toggles when all lower bits are ones; bits at or above
            // log2(MODULUS) never leave zero because illegal loads are rejected.
            localparam int LOG2M = $clog2(MODULUS);
            logic [WIDTH-1:0] ones;
            assign ones[0] = 1'b1;
            for (genvar i = 0; i < WIDTH; i++) begin : g_bit
                if (i < WIDTH - 1) begin : g_chain
                    assign ones[i+1] = ones[i] & q[i];
                end
                if (i < LOG2M) begin : g_tog
                    assign q_inc[i] = q[i] ^ ones[i];
                end else begin : g_zero
                    assign q_inc[i] = 1'b0;
                end
            end
        end else begin : g_cmp
            assign q_inc = at_top ? '0 : q + WIDTH'(1);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            q        <= '0;
            wrap     <= 1'b0;
            ovf      <= 1'b0;
            load_err <= 1'b0;
        end else begin
            wrap     <= do_wrap;
            load_err <= load & ~load_ok;
            if (load)
                q <= load_ok ? load_val : '0;
            else if (en)
                q <= q_inc;
            // A wrap in the same cycle as clr_ovf keeps the flag set
            if (do_wrap)
                ovf <= 1'b1;
            else if (clr_ovf)
                ovf <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sync_up_counter.sv
// Random + directed bench: three counters (mod 8, 6, 4) share stimulus against an
// arithmetic model; a two-stage mod-8 cascade is checked as a 0..63 counter.
module tb_sync_up_counter;
    logic clk = 1'b0;
    logic rst = 1'b0, en = 1'b0, load = 1'b0, clr_ovf = 1'b0;
    logic [2:0] load_val = '0;

    logic [2:0][2:0] qv;
    logic [2:0] tcv, wrv, ovv, erv;
    logic [2:0] lo_q, hi_q;
    logic lo_tc, hi_tc, lo_w, hi_w, lo_o, hi_o, lo_e, hi_e;

    int total = 0, bad = 0;
    int mods[3] = '{8, 6, 4};
    int mq[3], mw[3], mo[3], me[3];
    int cnt = 0;
    bit armed = 0;

    always #5 clk = ~clk;

    sync_up_counter #(.WIDTH(3), .MODULUS(8)) u8 (.clk(clk), .rst(rst), .en(en), .load(load),
        .load_val(load_val), .clr_ovf(clr_ovf), .q(qv[0]), .tc(tcv[0]), .wrap(wrv[0]),
        .ovf(ovv[0]), .load_err(erv[0]));
    sync_up_counter #(.WIDTH(3), .MODULUS(6)) u6 (.clk(clk), .rst(rst), .en(en), .load(load),
        .load_val(load_val), .clr_ovf(clr_ovf), .q(qv[1]), .tc(tcv[1]), .wrap(wrv[1]),
        .ovf(ovv[1]), .load_err(erv[1]));
    sync_up_counter #(.WIDTH(3), .MODULUS(4)) u4 (.clk(clk), .rst(rst), .en(en), .load(load),
        .load_val(load_val), .clr_ovf(clr_ovf), .q(qv[2]), .tc(tcv[2]), .wrap(wrv[2]),
        .ovf(ovv[2]), .load_err(erv[2]));

    sync_up_counter #(.WIDTH(3), .MODULUS(8)) u_lo (.clk(clk), .rst(rst), .en(en), .load(1'b0),
        .load_val(3'd0), .clr_ovf(1'b0), .q(lo_q), .tc(lo_tc), .wrap(lo_w), .ovf(lo_o),
        .load_err(lo_e));
    sync_up_counter #(.WIDTH(3), .MODULUS(8)) u_hi (.clk(clk), .rst(rst), .en(lo_tc), .load(1'b0),
        .load_val(3'd0), .clr_ovf(1'b0), .q(hi_q), .tc(hi_tc), .wrap(hi_w), .ovf(hi_o),
        .load_err(hi_e));

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit e, input bit l, input int lv, input bit c);
        @(negedge clk);
        rst = r; en = e; load = l; load_val = 3'(lv); clr_ovf = c;
        #1;
        if (armed)
            for (int k = 0; k < 3; k++)
                chk($sformatf("tc_m%0d", mods[k]), int'(tcv[k]),
                    int'(e && !l && mq[k] == mods[k] - 1));
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            bit wr;
            wr = 0;
            if (r) begin
                mq[k] = 0; mw[k] = 0; mo[k] = 0; me[k] = 0;
            end else begin
                me[k] = 0;
                if (l) begin
                    if (lv < mods[k]) mq[k] = lv;
                    else begin mq[k] = 0; me[k] = 1; end
                end else if (e) begin
                    wr = (mq[k] == mods[k] - 1);
                    mq[k] = (mq[k] + 1) % mods[k];
                end
                mw[k] = wr;
                if (wr) mo[k] = 1;
                else if (c) mo[k] = 0;
            end
        end
        if (r) cnt = 0;
        else if (e) cnt = (cnt + 1) % 64;
        if (r) armed = 1;
        #1;
        if (armed) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("q_m%0d", mods[k]), int'(qv[k]), mq[k]);
                chk($sformatf("wrap_m%0d", mods[k]), int'(wrv[k]), mw[k]);
                chk($sformatf("ovf_m%0d", mods[k]), int'(ovv[k]), mo[k]);
                chk($sformatf("lerr_m%0d", mods[k]), int'(erv[k]), me[k]);
            end
            chk("cascade", int'({hi_q, lo_q}), cnt);
        end
    endtask

    initial begin
        // reset with en and load active must still clear everything
        step(1, 1, 1, 3, 0);
        step(1, 1, 1, 3, 0);
        // free count across wraps
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0);
        // load has priority over en; then illegal loads for mod 6 and mod 4
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 1, 5, 0);
        step(0, 1, 1, 7, 0);
        step(0, 1, 0, 0, 0);
        // enable gating
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
        // clr_ovf coinciding with the mod-8 wrap
        for (int i = 0; i < 20; i++) step(0, 1, 0, 0, (mq[0] == 7));
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        // randomized traffic, including rare mid-count resets
        for (int i = 0; i < 500; i++)
            step(($urandom % 50) == 0, ($urandom % 4) != 0, ($urandom % 10) == 0,
                 int'($urandom % 8), ($urandom % 8) == 0);
        // full cascade sweep past 63
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 70; i++) step(0, 1, 0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sync_up_counter.md
# sync_up_counter

Synchronous, fully clocked N-bit modulo-M up counter: the counting-up, single-clock-domain counterpart of the team's 3-bit ripple down counter. Every state bit is clocked by the same `clk` edge, so `q` never shows ripple transitions. It adds parallel load, count enable, a terminal-count output for cascading, and wrap/overflow flags. It is used wherever a glitch-free count value must be sampled in the same clock domain.

## Interface
- WIDTH, 3, counter width in bits (1..16)
- MODULUS, 8, count modulus; legal range 2..2^WIDTH; count sequence is 0..MODULUS-1
- clk  input  1  single clock; all state changes on its rising edge
- rst  input  1  synchronous reset, active-high; sampled only at posedge clk
- en  input  1  count enable; increments q by one per clock while high
- load  input  1  parallel load strobe
- load_val  input  WIDTH  value loaded when load is high
- clr_ovf  input  1  clears the sticky overflow flag
- q  output  WIDTH  current count (registered)
- tc  output  1  terminal count, combinational: en & ~load & (q == MODULUS-1)
- wrap  output  1  registered one-cycle pulse, high in the cycle after q wrapped MODULUS-1 -> 0
- ovf  output  1  sticky overflow flag (registered); set on wrap
- load_err  output  1  registered one-cycle pulse; high the cycle after an illegal load

## Operation
- Priority at each posedge clk: rst > load > en > hold.
- rst=1: q=0, wrap=0, ovf=0, load_err=0. All other inputs are ignored that cycle.
- load=1, load_val < MODULUS: q<=load_val, load_err<=0. en is ignored.
- load=1, load_val >= MODULUS: q<=0, load_err<=1.
- en=1, no load: if q==MODULUS-1 then q<=0, wrap<=1, ovf<=1; else q<=q+1, wrap<=0.
- en=0, no load: q holds; wrap<=0.
- Loading MODULUS-1 does not produce wrap. wrap pulses only on a counted rollover.
- ovf set and clr_ovf in the same cycle: set wins, and ovf stays 1. clr_ovf alone makes ovf 0 on the next edge.
- Power-of-two MODULUS: bit i toggles when en & (q[i-1:0] all ones). This is the JK toggle (J=K=1) condition, with no modulus compare on q.
- Non-power-of-two MODULUS: an explicit compare against MODULUS-1 forces the next state to 0.
- Increment arithmetic is WIDTH bits wide; no carry leaves the block except through tc.
- Cascading: tc of stage n drives en of stage n+1. Both stages share clk.

## Timing
- q, wrap, ovf and load_err are registered. Load and count latency is 1 clock (value visible after the edge).
- tc is combinational from registered q and the en/load inputs. It is valid in the same cycle as the count that causes the rollover.
- Reset takes effect on the first posedge clk with rst=1. Reset has no asynchronous path, so there is no glitch if rst toggles between edges.
- Reset mid-count: q goes to 0 at that edge with no wrap pulse. Counting resumes from 0 on the first edge after rst falls if en=1.
- wrap and load_err are high for exactly one clock per event. Back-to-back wraps are only possible when MODULUS=1, which is illegal, so wraps are never adjacent.

## Test plan
- Reset: rst=1 for 2 cycles with en=1 and load=1 -> q=0, wrap=0, ovf=0, load_err=0. After release with en=1, q reads 1,2,3,... starting 1 cycle after rst falls.
- Free count, WIDTH=3, MODULUS=8, en=1 for 10 cycles -> q = 0..7,0,1. tc high only while q=7. wrap high the single cycle q=0 after 7. ovf stays 1. No intermediate q values at any sample.
- Modulus 6, WIDTH=3, en=1 -> q = 0..5,0. tc at q=5. q never reaches 6 or 7. wrap pulses once per 6 cycles.
- Load priority: q=2, en=1, load=1, load_val=5 -> q=5 next cycle with no increment. Then load_val=7 with MODULUS=6 -> q=0 and load_err=1 for one cycle.
- Enable gating and overflow clear: en=0 for 3 cycles -> q frozen. clr_ovf=1 in the same cycle as a wrap -> ovf remains 1. clr_ovf=1 on a later non-wrap cycle -> ovf=0.
- Cascade: two instances (WIDTH=3, MODULUS=8), low tc feeding high en, en=1 for 64 cycles -> the combined {hi,lo} value counts 0..63, then 0. The high stage increments exactly on the cycle after low q=7.
